ps2_key_matcher: RTL and testbench
==================================

PS2_KEY_MATCHER -- requirements
Module: ps2_key_matcher

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples needed to change the filtered clock level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clk cycles without a filtered falling edge before a partial frame aborts.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 ps2_dat  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-007 comparison_data  input  8  expected scan code of the next character; 00 means none.
REQ-008 num_char  input  8  characters in the current word.
REQ-009 word_clear  input  1  one-cycle pulse that starts a new word.
REQ-010 scan_code  output  8  last accepted make code.
REQ-011 scan_valid  output  1  one-cycle pulse when scan_code updates.
REQ-012 get_next_character  output  1  one-cycle pulse when a correct key is typed.
REQ-013 char_count  output  8  correct characters typed in the current word.
REQ-014 mistake_count  output  8  wrong keystrokes in the current word, saturating.
REQ-015 word_done  output  1  level, high while char_count >= num_char.
REQ-016 frame_error  output  1  one-cycle pulse on parity, stop-bit or timeout failure.

Function
REQ-017 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; the filtered clock changes level only after FILTER_LEN equal samples.
REQ-018 The frame FSM SHALL use states IDLE, DATA, PARITY and STOP, sampling synchronized ps2_dat on each filtered falling edge.
- IDLE: sample 0 -> DATA with bit counter 0; sample 1 -> stay in IDLE.
- DATA: 8 bits, LSB first; after bit 7 -> PARITY.
- PARITY: odd parity over the 8 data bits and the parity bit; result held.
- STOP: sample 1 with good parity -> byte accepted; otherwise frame_error. Both cases return to IDLE.
REQ-019 In any state other than IDLE, TIMEOUT_CYCLES cycles with no filtered falling edge SHALL force IDLE and pulse frame_error.
REQ-020 Accepted byte F0 SHALL set break_pending; the next accepted byte is discarded, clears break_pending, and clears held_code if it equals held_code.
REQ-021 Accepted byte E0 SHALL set ext_pending; the next accepted byte, make or break, is discarded and produces no output.
REQ-022 A non-prefix make byte equal to held_code SHALL be suppressed (typematic repeat).
REQ-023 Any other non-prefix make byte SHALL load scan_code and held_code and pulse scan_valid.
- scan_valid occurs 1 cycle after the STOP sample.
REQ-024 Any frame_error SHALL clear break_pending and ext_pending.
REQ-025 On scan_valid with word_done=0:
- scan_code == comparison_data and comparison_data != 00: pulse get_next_character on the next cycle and increment char_count.
- otherwise: increment mistake_count, saturating at FF.
REQ-026 On scan_valid with word_done=1, counters SHALL be unchanged and get_next_character SHALL not pulse.
REQ-027 word_done SHALL be registered, equal to (char_count >= num_char), and updated every cycle; num_char=0 gives word_done=1.
REQ-028 word_clear SHALL zero char_count and mistake_count.
- Clear wins over a simultaneous scan_valid; that keystroke is dropped.
- word_clear SHALL NOT disturb the frame FSM, held_code or the prefix flags.
REQ-029 char_count SHALL not exceed num_char; it does not wrap.

Reset
REQ-030 resetn low SHALL asynchronously force the following, including mid-frame:
- FSM to IDLE; bit counter and timeout counter to 0.
- break_pending, ext_pending and held_code to 0.
- scan_code, char_count and mistake_count to 00.
- scan_valid, get_next_character and frame_error to 0.
- word_done to 0 until the first clocked evaluation.
- Synchronizer and filter flops to 1 (idle bus level).

Structure
REQ-031 Package ps2_pkg SHALL hold BREAK_PREFIX=F0, EXT_PREFIX=E0 and the frame FSM state encoding.
REQ-032 Sub-module ps2_frame_rx SHALL contain the synchronizer, filter, frame FSM and timeout, and output byte/byte_valid/frame_error to the top.
REQ-033 The top SHALL contain prefix decode, repeat suppression and matching.

Verification
REQ-034 Frame 1C (parity 0, stop 1) with comparison_data=1C, num_char=03: scan_valid, get_next_character pulse, char_count=01.
REQ-035 Sequence 24, F0 24, 24 with comparison_data=24 throughout: two get_next_character pulses, mistake_count=00.
REQ-036 Sequence 24, 24, 24 with no break: one scan_valid only.
REQ-037 Frame 1C with a flipped parity bit: frame_error pulse, no scan_valid, counters unchanged.
REQ-038 Five edges, then 60000 idle cycles, then a valid 2C: frame_error at timeout, 2C accepted afterwards.
REQ-039 Sequences:
- E0 75: no scan_valid.
- Wrong key 1D with comparison_data=2A: mistake_count=01.
- word_clear coincident with a matching scan_valid: both counters 00, no get_next_character.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and frame FSM encoding for the PS/2 key matcher.
//   BREAK_PREFIX / EXT_PREFIX : scan-code prefix bytes
//   frame_state_t             : receive frame FSM states
package ps2_pkg;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_key_matcher_if.sv
// ps2_key_matcher_if: word/character handshake between the typing-game
// controller (master) and the key matcher (slave).
//   comparison_data, num_char, word_clear          : master -> slave
//   scan_code, scan_valid, get_next_character,
//   char_count, mistake_count, word_done,
//   frame_error                                    : slave -> master
interface ps2_key_matcher_if;

    logic [7:0] comparison_data;
    logic [7:0] num_char;
    logic       word_clear;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       get_next_character;
    logic [7:0] char_count;
    logic [7:0] mistake_count;
    logic       word_done;
    logic       frame_error;

    modport master (
        output comparison_data, num_char, word_clear,
        input  scan_code, scan_valid, get_next_character,
               char_count, mistake_count, word_done, frame_error
    );

    modport slave (
        input  comparison_data, num_char, word_clear,
        output scan_code, scan_valid, get_next_character,
               char_count, mistake_count, word_done, frame_error
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 line synchronizer, clock glitch filter and 11-bit frame
// receiver with inactivity timeout.
//   clk, resetn       : system clock, async active-low reset
//   ps2_clk, ps2_dat  : raw asynchronous PS/2 lines
//   rx_byte           : received data byte (valid with rx_valid)
//   rx_valid          : one-cycle strobe, good parity and stop bit
//   rx_error          : one-cycle strobe, bad parity/stop or timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_error
);

    localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT_CYCLES - 1);

    logic [1:0]     clk_sync, dat_sync;
    logic           s_clk, s_dat;
    logic           filt;
    logic [FCW-1:0] filt_cnt;
    logic           fall;

    frame_state_t   state_q, state_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic           par_q, par_d;
    logic [TCW-1:0] to_q, to_d;

    assign s_clk = clk_sync[1];
    assign s_dat = dat_sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            // Count consecutive samples that disagree with the filtered level;
            // any agreeing sample restarts the count.
            if (s_clk == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt     <= s_clk;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Strobe in the cycle the filtered clock is about to drop.
    assign fall = filt && !s_clk && (filt_cnt == FILT_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_d    = par_q;
        to_d     = to_q;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        if (state_q == IDLE) begin
            to_d = '0;
            if (fall && !s_dat) begin
                state_d = DATA;
                bit_d   = '0;
            end
        end else if (fall) begin
            to_d = '0;
            case (state_q)
                DATA: begin
                    sh_d  = {s_dat, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = ^{sh_q, s_dat};
                    state_d = STOP;
                end
                default: begin
                    if (s_dat && par_q) begin
                        rx_valid = 1'b1;
                    end else begin
                        rx_error = 1'b1;
                    end
                    state_d = IDLE;
                end
            endcase
        end else if (to_q == TO_MAX) begin
            state_d  = IDLE;
            to_d     = '0;
            rx_error = 1'b1;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    assign rx_byte = sh_q;

endmodule

// File: rtl/ps2_key_matcher.sv
// ps2_key_matcher: receives PS/2 scan codes, strips break/extended sequences
// and typematic repeats, and scores each make code against the expected
// character of the current word.
//   clk, resetn       : system clock, async active-low reset
//   ps2_clk, ps2_dat  : raw asynchronous PS/2 lines
//   bus (slave)       : word/character handshake, see ps2_key_matcher_if
module ps2_key_matcher
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ps2_clk,
    input  logic             ps2_dat,
    ps2_key_matcher_if.slave bus
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_error;

    logic       break_pending, ext_pending;
    logic [7:0] held_code;
    logic [7:0] scan_code;
    logic       scan_valid, frame_error;
    logic [7:0] char_count, mistake_count;
    logic       get_next_character, word_done;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (clk),
        .resetn  (resetn),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_error(rx_error)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            held_code     <= '0;
            scan_code     <= '0;
            scan_valid    <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            frame_error <= rx_error;
            if (rx_error) begin
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
            end else if (rx_valid) begin
                if (ext_pending) begin
                    // An extended break (E0 F0 xx) keeps the extension alive
                    // across the F0 so its final byte is also swallowed.
                    if (rx_byte != BREAK_PREFIX) begin
                        ext_pending <= 1'b0;
                    end
                end else if (break_pending) begin
                    break_pending <= 1'b0;
                    if (rx_byte == held_code) begin
                        held_code <= '0;
                    end
                end else if (rx_byte == BREAK_PREFIX) begin
                    break_pending <= 1'b1;
                end else if (rx_byte == EXT_PREFIX) begin
                    ext_pending <= 1'b1;
                end else if (rx_byte != held_code) begin
                    held_code  <= rx_byte;
                    scan_code  <= rx_byte;
                    scan_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            char_count         <= '0;
            mistake_count      <= '0;
            get_next_character <= 1'b0;
            word_done          <= 1'b0;
        end else begin
            get_next_character <= 1'b0;
            word_done          <= (char_count >= bus.num_char);
            if (bus.word_clear) begin
                char_count    <= '0;
                mistake_count <= '0;
            end else if (scan_valid && !word_done) begin
                if (scan_code == bus.comparison_data && bus.comparison_data != 8'h00) begin
                    if (char_count < bus.num_char) begin
                        char_count         <= char_count + 8'd1;
                        get_next_character <= 1'b1;
                    end
                end else if (mistake_count != 8'hFF) begin
                    mistake_count <= mistake_count + 8'd1;
                end
            end
        end
    end

    assign bus.scan_code          = scan_code;
    assign bus.scan_valid         = scan_valid;
    assign bus.frame_error        = frame_error;
    assign bus.char_count         = char_count;
    assign bus.mistake_count      = mistake_count;
    assign bus.get_next_character = get_next_character;
    assign bus.word_done          = word_done;

endmodule

// File: tb/tb_ps2_key_matcher.sv
// tb_ps2_key_matcher: drives PS/2 frames into ps2_key_matcher; expected make
// codes are queued as frames are sent and checked as scan_valid appears.
module tb_ps2_key_matcher;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_key_matcher_if bus();

    ps2_key_matcher #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(50000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_q[$];
    int unsigned sv_cnt = 0, gnc_cnt = 0, fe_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop on scan_valid, pulse counters.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.scan_valid) begin
                sv_cnt++;
                if (exp_q.size() == 0) check("unexpected_scan_valid", 32'd1, 32'd0);
                else check("scan_code", {24'd0, bus.scan_code}, {24'd0, exp_q.pop_front()});
            end
            if (bus.get_next_character) gnc_cnt++;
            if (bus.frame_error) fe_cnt++;
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (20) @(posedge clk);
    endtask

    task automatic clear_word();
        @(negedge clk) bus.word_clear = 1'b1;
        @(negedge clk) bus.word_clear = 1'b0;
    endtask

    int unsigned sv0, gnc0, fe0;
    logic hit;

    task automatic mark();
        sv0 = sv_cnt; gnc0 = gnc_cnt; fe0 = fe_cnt;
    endtask

    initial begin
        bus.comparison_data = 8'h00;
        bus.num_char = 8'h00;
        bus.word_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_scan_code", {24'd0, bus.scan_code}, 32'h00);
        check("rst_char_count", {24'd0, bus.char_count}, 32'h00);
        check("rst_mistake_count", {24'd0, bus.mistake_count}, 32'h00);
        check("rst_pulses", {29'd0, bus.scan_valid, bus.get_next_character, bus.frame_error}, 32'd0);
        check("rst_word_done", {31'd0, bus.word_done}, 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("num_char0_word_done", {31'd0, bus.word_done}, 32'd1);
        bus.num_char = 8'h03;
        repeat (3) @(negedge clk);
        check("word_done_low", {31'd0, bus.word_done}, 32'd0);

        // Single matching key
        mark();
        bus.comparison_data = 8'h1C;
        exp_q.push_back(8'h1C);
        send(8'h1C, 1'b0);
        check("match_char_count", {24'd0, bus.char_count}, 32'h01);
        check("match_gnc", gnc_cnt - gnc0, 32'd1);

        // Press, break, press again
        clear_word(); mark();
        bus.comparison_data = 8'h24;
        exp_q.push_back(8'h24);
        send(8'h24, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h24, 1'b0);
        exp_q.push_back(8'h24);
        send(8'h24, 1'b0);
        check("rebreak_gnc", gnc_cnt - gnc0, 32'd2);
        check("rebreak_mistake", {24'd0, bus.mistake_count}, 32'h00);
        check("rebreak_char_count", {24'd0, bus.char_count}, 32'h02);

        // Typematic repeat
        send(8'hF0, 1'b0);
        send(8'h24, 1'b0);
        clear_word(); mark();
        exp_q.push_back(8'h24);
        for (int i = 0; i < 3; i++) send(8'h24, 1'b0);
        check("repeat_scan_valid", sv_cnt - sv0, 32'd1);

        // Bad parity
        clear_word(); mark();
        bus.comparison_data = 8'h1C;
        send(8'h1C, 1'b1);
        check("parity_frame_error", fe_cnt - fe0, 32'd1);
        check("parity_scan_valid", sv_cnt - sv0, 32'd0);
        check("parity_counts", {16'd0, bus.char_count, bus.mistake_count}, 32'd0);

        // Partial frame then timeout
        mark();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (60000) @(posedge clk);
        check("timeout_frame_error", fe_cnt - fe0, 32'd1);
        bus.comparison_data = 8'h2C;
        exp_q.push_back(8'h2C);
        send(8'h2C, 1'b0);
        check("post_timeout_char", {24'd0, bus.char_count}, 32'h01);

        // Extended key
        mark();
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        check("ext_scan_valid", sv_cnt - sv0, 32'd0);

        // Wrong key
        clear_word(); mark();
        bus.comparison_data = 8'h2A;
        exp_q.push_back(8'h1D);
        send(8'h1D, 1'b0);
        check("wrong_mistake", {24'd0, bus.mistake_count}, 32'h01);
        check("wrong_char", {24'd0, bus.char_count}, 32'h00);

        // Clear coincident with a matching scan_valid
        mark();
        bus.comparison_data = 8'h4D;
        exp_q.push_back(8'h4D);
        hit = 1'b0;
        fork
            send(8'h4D, 1'b0);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (bus.scan_valid) begin
                        bus.word_clear = 1'b1;
                        @(negedge clk) bus.word_clear = 1'b0;
                        hit = 1'b1;
                        break;
                    end
                end
            end
        join
        check("clr_scan_valid_seen", {31'd0, hit}, 32'd1);
        check("clr_counts", {16'd0, bus.char_count, bus.mistake_count}, 32'd0);
        check("clr_gnc", gnc_cnt - gnc0, 32'd0);

        // Word complete: further keys leave counters alone
        clear_word(); mark();
        bus.num_char = 8'h01;
        bus.comparison_data = 8'h5A;
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b0);
        check("done_char", {24'd0, bus.char_count}, 32'h01);
        check("done_level", {31'd0, bus.word_done}, 32'd1);
        send(8'hF0, 1'b0);
        send(8'h5A, 1'b0);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b0);
        check("done_frozen", {16'd0, bus.char_count, bus.mistake_count}, 32'h0100);
        check("done_gnc", gnc_cnt - gnc0, 32'd1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
